mem_wb_pipe_reg: RTL
====================

Name: mem_wb_pipe_reg

Overview:
- Parametrised successor to the fixed MEM/WB latch in the 5-stage MIPS pipeline.
- Carries the WB control bits, the destination register index and NUM_DATA data words (ALU result, memory read data, ...) from one stage to the next.
- Adds a valid/ready handshake with a 2-entry skid buffer, stall back-pressure and flush-to-bubble.
- The same module is instantiated at ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 32, width of each data word.
- NUM_DATA, 2, number of data words carried (payload is NUM_DATA*DATA_W bits, word 0 in the LSBs).
- CTRL_W, 2, width of the control bundle (RegWrite, MemToReg at MEM/WB).
- DST_W, 5, width of the destination register index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: sampled on the rising edge of clk; 0 = reset.
- flush  in  1  kill all held entries; they become bubbles.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_dst  in  DST_W  destination register index.
- in_data  in  NUM_DATA*DATA_W  packed data words.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_ctrl  out  CTRL_W  head control bundle; forced to 0 when out_valid=0.
- out_dst  out  DST_W  head destination index.
- out_data  out  NUM_DATA*DATA_W  head data words.

Behaviour:
- Storage and naming:
  - Two entry registers: main (drives the outputs) and skid. Each holds ctrl, dst, data and a valid bit.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- States, encoded by the valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
- in_ready:
  - Equals ~skid.valid & rst.
  - It is a function of registers and rst only, never of in_valid or out_ready (no combinational path in to out).
- EMPTY:
  - Accept: entry loads into main → ONE.
  - Latency from in_valid to out_valid is 1 cycle.
- ONE:
  - Accept and consume: main reloads with the new entry; stay ONE.
  - Accept, no consume: new entry loads into skid → FULL.
  - Consume only → EMPTY.
- FULL:
  - in_ready=0.
  - Consume: skid moves to main → ONE.
  - No consume: hold everything.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Payload: passes bit-exact with no arithmetic; widths are fixed by the parameters.
- out_ctrl is ANDed with out_valid, so a bubble never asserts RegWrite or MemWrite. out_dst and out_data hold stale values and are don't-care when out_valid=0.
- flush=1 on a clock edge:
  - Both valid bits clear → EMPTY, regardless of in_valid and out_ready.
  - A same-cycle input is discarded; flush dominates accept.
  - Payload registers need not clear.
- rst=0 on a clock edge:
  - All valid bits, ctrl, dst and data registers are set to 0.
  - in_ready=0 while rst=0 and becomes 1 in the first cycle with rst=1.
  - Reset dominates flush.
  - Reset mid-transfer loses both entries, with no partial output.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package pipe_pkg:
  - Default width constants DATA_W_DEF=32, DST_W_DEF=5.
  - MEM/WB control bit positions WB_REGWRITE=0, WB_MEMTOREG=1.
  - Typedef pipe_state_t {EMPTY, ONE, FULL}, used by the bench and the assertions.
- One natural sub-module, pipe_entry_reg: a width-generic register with synchronous active-low reset and a load enable. It is instantiated twice (main and skid).

Test Plan:
- Reset and initial state: hold rst=0 for 3 cycles with in_valid=1 → out_valid=0, out_ctrl=0, out_data=0, in_ready=0; release rst → in_ready=1 on the next cycle.
- Single pass: send ctrl=2'b01, dst=5'd9, data={32'hDEAD_BEEF, 32'h0000_0010} with out_ready=1 → exactly one cycle later out_valid=1 with identical fields; the following cycle out_valid=0 and out_ctrl=0.
- Back-pressure and skid: hold out_ready=0 and offer entries A=1, B=2, C=3 on consecutive cycles → A and B accepted and C refused (in_ready=0 after B, state FULL); raise out_ready → outputs A, B, C in order with no loss.
- Full throughput: stream 16 entries with in_valid=1 and out_ready=1 → one output per cycle with data 0..15 in order and in_ready constantly 1.
- Flush: in FULL, assert flush together with in_valid=1, data=32'h55 → next cycle out_valid=0, out_ctrl=0, in_ready=1, and 32'h55 never appears on the output.
- Reset mid-operation: in FULL, pulse rst=0 for 1 cycle alongside flush=1 → EMPTY, all outputs 0; a new entry afterwards passes with 1-cycle latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-register family (ID/EX, EX/MEM, MEM/WB).
// Contents:
//   DATA_W_DEF, DST_W_DEF     default data word width and register index width
//   WB_REGWRITE, WB_MEMTOREG  bit positions inside the MEM/WB control bundle
//   pipe_state_t              occupancy of the two-entry register, derived from
//                             the main/skid valid bits
package pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int DST_W_DEF   = 5;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// Width-generic payload register with a load enable.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset; clears the stored value to 0
//   load  capture d on the next rising edge
//   d     next value
//   q     stored value
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// Pipeline register with a valid/ready handshake and a two-entry skid buffer.
// Carries a control bundle, a destination register index and NUM_DATA data
// words bit-exact from one stage to the next, in strict FIFO order.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side. in_ready depends only on registers and rst, so there is
// no combinational path from out_ready to in_ready. out_valid may be held
// indefinitely; the payload stays stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   flush            turn every held entry into a bubble; same-cycle input dropped
//   in_valid/ready   upstream handshake
//   in_ctrl/dst/data upstream payload (data word 0 in the LSBs)
//   out_valid/ready  downstream handshake
//   out_ctrl         head control bundle, masked to 0 for bubbles
//   out_dst/data     head payload (stale when out_valid=0)
module mem_wb_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = 2,
  parameter int DST_W    = DST_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DST_W-1:0]           in_dst,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DST_W-1:0]           out_dst,
  output logic [NUM_DATA*DATA_W-1:0] out_data
);

  localparam int PW = NUM_DATA * DATA_W;
  localparam int EW = CTRL_W + DST_W + PW;

  logic        r_main_valid;
  logic        r_skid_valid;
  pipe_state_t w_state;

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_main_load;
  logic          w_skid_load;
  logic          w_main_valid_nxt;
  logic          w_skid_valid_nxt;
  logic [EW-1:0] w_in_entry;
  logic [EW-1:0] w_main_d;
  logic [EW-1:0] w_main_q;
  logic [EW-1:0] w_skid_q;

  assign in_ready   = ~r_skid_valid & rst;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_valid & out_ready;
  assign w_in_entry = {in_ctrl, in_dst, in_data};

  // Occupancy is fully described by the two valid bits.
  always_comb begin
    w_state = EMPTY;
    if (r_skid_valid)      w_state = FULL;
    else if (r_main_valid) w_state = ONE;
  end

  always_comb begin
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_valid_nxt = 1'b0;
    w_skid_valid_nxt = 1'b0;
    case (w_state)
      EMPTY: begin
        w_main_load      = w_in_fire;
        w_main_valid_nxt = w_in_fire;
      end
      ONE: begin
        // Head leaving while a new entry arrives: main reloads in place.
        // Head stalled while a new entry arrives: the entry parks in skid.
        w_main_load      = w_in_fire & w_out_fire;
        w_skid_load      = w_in_fire & ~w_out_fire;
        w_main_valid_nxt = w_in_fire | ~w_out_fire;
        w_skid_valid_nxt = w_in_fire & ~w_out_fire;
      end
      FULL: begin
        w_main_load      = w_out_fire;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = ~w_out_fire;
      end
      default: begin
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_valid_nxt = 1'b0;
        w_skid_valid_nxt = 1'b0;
      end
    endcase
  end

  // In FULL the skid entry is older than anything at the input.
  assign w_main_d = r_skid_valid ? w_skid_q : w_in_entry;

  // Flush only clears the valid bits; payload contents become don't-care.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  pipe_entry_reg #(.W(EW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (w_main_load),
    .d    (w_main_d),
    .q    (w_main_q)
  );

  pipe_entry_reg #(.W(EW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (w_skid_load),
    .d    (w_in_entry),
    .q    (w_skid_q)
  );

  assign out_valid = r_main_valid;
  assign out_ctrl  = w_main_q[EW-1 -: CTRL_W] & {CTRL_W{r_main_valid}};
  assign out_dst   = w_main_q[PW +: DST_W];
  assign out_data  = w_main_q[PW-1:0];

endmodule
